// File: rtl/note_sequencer.sv
// Record/playback engine: folds string/bar activity into one note frame per tempo
// tick, stores frames in a single-port block RAM and replays them once or looped.
module note_sequencer #(
  parameter  int STRINGS = 6,
  parameter  int FRETS   = 5,
  parameter  int DEPTH   = 64,
  localparam int AW      = $clog2(DEPTH),
  localparam int NOTE_W  = STRINGS * FRETS
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              tick,
  input  logic [STRINGS-1:0] strings,
  input  logic [FRETS-2:0]  frets,
  input  logic              start,
  input  logic              stop,
  input  logic              mode,
  input  logic              loop,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic [AW-1:0]     address,
  output logic [AW:0]       length,
  output logic [2:0]        state,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int FW = (FRETS > 1) ? $clog2(FRETS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REC_ARM  = 3'd1;
  localparam logic [2:0] S_RECORD   = 3'd2;
  localparam logic [2:0] S_PLAY_ARM = 3'd3;
  localparam logic [2:0] S_PLAY     = 3'd4;

  localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  logic [2:0]        state_reg, state_next;
  logic [AW-1:0]     address_reg;
  logic [AW:0]       length_reg;
  logic              overflow_reg;
  logic              loop_reg;
  logic              done_reg;
  logic [NOTE_W-1:0] acc_reg;
  logic [NOTE_W-1:0] rec_frame_reg;
  logic [NOTE_W-1:0] rd_data_reg;
  logic [NOTE_W-1:0] note_out_reg;
  logic              note_valid_reg;
  logic              pend_reg;
  logic              pend_play_reg;

  logic [NOTE_W-1:0] mem [DEPTH];

  logic [FW-1:0]     fret_sel;
  logic [NOTE_W-1:0] enc;
  logic [NOTE_W-1:0] frame;
  logic              idle, commit, play_tick, play_last, end_play;
  logic              stop_busy, empty_play, rd_en, done_next;
  logic [AW-1:0]     rd_addr;

  // Highest-indexed bar wins; no bar means open string.
  always_comb begin
    fret_sel = '0;
    for (int i = 1; i < FRETS; i++) begin
      if (frets[i-1]) fret_sel = FW'(i);
    end
  end

  generate
    for (genvar gi = 0; gi < FRETS; gi++) begin : g_enc
      assign enc[gi*STRINGS +: STRINGS] = (fret_sel == FW'(gi)) ? strings : '0;
    end
  endgenerate

  assign idle       = (state_reg == S_IDLE);
  assign frame      = acc_reg | enc;
  assign commit     = (state_reg == S_RECORD) && tick;
  assign play_tick  = (state_reg == S_PLAY) && tick;
  assign play_last  = ({1'b0, address_reg} == (length_reg - LEN_ONE));
  assign end_play   = play_tick && play_last && !loop_reg;
  assign stop_busy  = stop && !idle;
  assign empty_play = idle && start && !mode && (length_reg == '0);
  assign rd_en      = ((state_reg == S_PLAY_ARM) && tick) || (play_tick && !end_play);
  assign rd_addr    = ((state_reg == S_PLAY_ARM) || play_last) ? '0 : address_reg + ADDR_ONE;

  // State register
  always_ff @(posedge clk) begin
    if (srst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; stop is applied after the tick action of the same cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (mode)                    state_next = S_REC_ARM;
          else if (length_reg != '0)   state_next = S_PLAY_ARM;
        end
      end
      S_REC_ARM:  if (tick) state_next = S_RECORD;
      S_RECORD:   if (commit && (address_reg == '1)) state_next = S_IDLE;
      S_PLAY_ARM: if (tick) state_next = S_PLAY;
      S_PLAY:     if (end_play) state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
    if (stop_busy) state_next = S_IDLE;
  end

  // Output logic
  always_comb begin
    state     = state_reg;
    busy      = (state_reg != S_IDLE);
    done_next = ((state_next == S_IDLE) && (state_reg != S_IDLE)) || empty_play;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      address_reg    <= '0;
      length_reg     <= '0;
      overflow_reg   <= 1'b0;
      loop_reg       <= 1'b0;
      done_reg       <= 1'b0;
      acc_reg        <= '0;
      rec_frame_reg  <= '0;
      note_out_reg   <= '0;
      note_valid_reg <= 1'b0;
      pend_reg       <= 1'b0;
      pend_play_reg  <= 1'b0;
    end else begin
      done_reg       <= done_next;
      note_valid_reg <= 1'b0;
      acc_reg        <= ((state_reg == S_RECORD) && !commit) ? frame : '0;

      if (idle && start) begin
        address_reg <= '0;
        loop_reg    <= loop;
        if (mode) begin
          length_reg   <= '0;
          overflow_reg <= 1'b0;
        end
      end

      if (commit) begin
        address_reg   <= address_reg + ADDR_ONE;
        length_reg    <= {1'b0, address_reg} + LEN_ONE;
        rec_frame_reg <= frame;
        if (address_reg == '1) overflow_reg <= 1'b1;
      end

      if (play_tick) address_reg <= play_last ? '0 : address_reg + ADDR_ONE;

      // One-cycle stage so recorded frames appear with the same latency as RAM reads
      pend_reg      <= commit || rd_en;
      pend_play_reg <= rd_en;
      if (pend_reg) begin
        note_out_reg   <= pend_play_reg ? rd_data_reg : rec_frame_reg;
        note_valid_reg <= 1'b1;
      end

      if (end_play || stop_busy) begin
        note_out_reg   <= '0;
        note_valid_reg <= 1'b0;
        pend_reg       <= 1'b0;
      end
    end
  end

  // Frame store is deliberately not reset; length gates what is reachable.
  always_ff @(posedge clk) begin
    if (commit && !srst) mem[address_reg] <= frame;
    if (rd_en && !srst)  rd_data_reg <= mem[rd_addr];
  end

  assign note_out   = note_out_reg;
  assign note_valid = note_valid_reg;
  assign address    = address_reg;
  assign length     = length_reg;
  assign done       = done_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer at DEPTH=4: record, one-shot and looped play,
// overflow, empty play and reset behaviour, with a frame scoreboard on note_valid.
module tb_note_sequencer;

  localparam int STRINGS = 6;
  localparam int FRETS   = 5;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        srst, tick, start, stop, mode, loop;
  logic [5:0]  strings;
  logic [3:0]  frets;
  logic [29:0] note_out;
  logic        note_valid;
  logic [1:0]  address;
  logic [2:0]  length;
  logic [2:0]  state;
  logic        busy, done, overflow;

  int total = 0;
  int bad   = 0;
  logic [29:0] sb [$];

  always #5 clk = ~clk;

  note_sequencer #(.STRINGS(STRINGS), .FRETS(FRETS), .DEPTH(DEPTH)) dut (
    .clk(clk), .srst(srst), .tick(tick), .strings(strings), .frets(frets),
    .start(start), .stop(stop), .mode(mode), .loop(loop),
    .note_out(note_out), .note_valid(note_valid), .address(address),
    .length(length), .state(state), .busy(busy), .done(done), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every note_valid pulse must match the oldest expected frame
  always @(negedge clk) begin
    if (srst === 1'b0 && note_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_frame observed=0x%0h expected=none", note_out);
      end else begin
        logic [29:0] e;
        e = sb.pop_front();
        chk("note_out", 32'(note_out), 32'(e));
        $display("frame out 0x%08h expected 0x%08h", note_out, e);
      end
    end
  end

  task automatic rec_frame(input logic [5:0] s, input logic [3:0] f, input logic [31:0] exp,
                           input int exp_addr, input int exp_len, input int exp_done);
    strings = s;
    frets   = f;
    repeat (3) step();
    tick = 1'b1;
    sb.push_back(30'(exp));
    step();
    tick    = 1'b0;
    strings = '0;
    frets   = '0;
    chk("rec_addr", 32'(address), 32'(exp_addr));
    chk("rec_len", 32'(length), 32'(exp_len));
    chk("rec_done", 32'(done), 32'(exp_done));
    chk("rec_valid_t1", 32'(note_valid), 0);
    step();
    chk("rec_valid_t2", 32'(note_valid), 1);
  endtask

  task automatic play_tick(input logic [31:0] exp, input int exp_addr);
    repeat (3) step();
    tick = 1'b1;
    sb.push_back(30'(exp));
    step();
    tick = 1'b0;
    chk("play_addr", 32'(address), 32'(exp_addr));
    chk("play_valid_t1", 32'(note_valid), 0);
    step();
    chk("play_valid_t2", 32'(note_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; loop = 1'b0;
    strings = '0; frets = '0;
    repeat (2) step();
    chk("rst_state", 32'(state), 0);
    chk("rst_note_out", 32'(note_out), 0);
    chk("rst_valid", 32'(note_valid), 0);
    chk("rst_addr", 32'(address), 0);
    chk("rst_len", 32'(length), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    srst = 1'b0;
    step();

    // stop in IDLE is ignored
    stop = 1'b1; step(); stop = 1'b0;
    chk("idle_stop_done", 32'(done), 0);
    chk("idle_stop_state", 32'(state), 0);

    // record three frames
    mode = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("rec_arm_state", 32'(state), 1);
    chk("rec_arm_busy", 32'(busy), 1);
    tick = 1'b1; step(); tick = 1'b0;
    chk("record_state", 32'(state), 2);
    mode = 1'b0; start = 1'b1; step(); start = 1'b0; mode = 1'b1;
    chk("busy_start_ignored", 32'(state), 2);
    rec_frame(6'b000001, 4'b0000, 32'h0000_0001, 1, 1, 0);
    rec_frame(6'b000010, 4'b0010, 32'h0000_2000, 2, 2, 0);
    rec_frame(6'b100000, 4'b1001, 32'h2000_0000, 3, 3, 0);
    step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("rec_stop_state", 32'(state), 0);
    chk("rec_stop_done", 32'(done), 1);
    chk("rec_stop_len", 32'(length), 3);
    chk("rec_stop_busy", 32'(busy), 0);
    chk("rec_stop_note", 32'(note_out), 0);
    step();
    chk("done_one_cycle", 32'(done), 0);

    // one-shot playback
    mode = 1'b0; loop = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("play_arm_state", 32'(state), 3);
    play_tick(32'h0000_0001, 0);
    play_tick(32'h0000_2000, 1);
    play_tick(32'h2000_0000, 2);
    repeat (3) step();
    chk("last_frame_held", 32'(note_out), 32'h2000_0000);
    tick = 1'b1; step(); tick = 1'b0;
    chk("end_play_note", 32'(note_out), 0);
    chk("end_play_done", 32'(done), 1);
    chk("end_play_busy", 32'(busy), 0);
    chk("end_play_state", 32'(state), 0);
    step();
    chk("end_play_no_valid", 32'(note_valid), 0);

    // looped playback, then stop together with tick
    loop = 1'b1; start = 1'b1; step(); start = 1'b0;
    play_tick(32'h0000_0001, 0);
    play_tick(32'h0000_2000, 1);
    play_tick(32'h2000_0000, 2);
    play_tick(32'h0000_0001, 0);
    repeat (3) step();
    tick = 1'b1; stop = 1'b1; step(); tick = 1'b0; stop = 1'b0;
    chk("loop_stop_state", 32'(state), 0);
    chk("loop_stop_done", 32'(done), 1);
    chk("loop_stop_note", 32'(note_out), 0);
    repeat (2) step();
    loop = 1'b0;

    // overflow at DEPTH frames
    mode = 1'b1; start = 1'b1; step(); start = 1'b0;
    chk("ovf_clear_len", 32'(length), 0);
    tick = 1'b1; step(); tick = 1'b0;
    rec_frame(6'b000100, 4'b0000, 32'h0000_0004, 1, 1, 0);
    rec_frame(6'b001000, 4'b0001, 32'h0000_0200, 2, 2, 0);
    rec_frame(6'b010000, 4'b0100, 32'h0040_0000, 3, 3, 0);
    rec_frame(6'b111111, 4'b1111, 32'h3F00_0000, 0, 4, 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_state", 32'(state), 0);
    chk("ovf_busy", 32'(busy), 0);
    repeat (3) step();
    tick = 1'b1; step(); tick = 1'b0;
    chk("ovf_tick_state", 32'(state), 0);
    chk("ovf_tick_len", 32'(length), 4);
    chk("ovf_tick_addr", 32'(address), 0);
    step();
    chk("ovf_tick_valid", 32'(note_valid), 0);

    // reset in the middle of playback
    mode = 1'b0; loop = 1'b1; start = 1'b1; step(); start = 1'b0;
    play_tick(32'h0000_0004, 0);
    play_tick(32'h0000_0200, 1);
    step();
    srst = 1'b1; step(); srst = 1'b0;
    chk("mid_rst_state", 32'(state), 0);
    chk("mid_rst_note", 32'(note_out), 0);
    chk("mid_rst_len", 32'(length), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_busy", 32'(busy), 0);

    // empty playback
    loop = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("empty_done", 32'(done), 1);
    chk("empty_busy", 32'(busy), 0);
    chk("empty_state", 32'(state), 0);
    step();
    chk("empty_done_clear", 32'(done), 0);
    chk("empty_busy_after", 32'(busy), 0);
    chk("empty_valid", 32'(note_valid), 0);

    repeat (2) step();
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
